// File: rtl/dmac_ahbl_regs.sv
// AHB-Lite zero-wait-state register file for the DMA master engine.
// Optional done interrupt (IE register, irq line) enabled by DMAC_REGS_IRQ_EN.
module dmac_ahbl_regs (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic [31:0] saddr,
   output logic [31:0] daddr,
   output logic [31:0] icra,
   output logic [31:0] icrv,
   output logic [2:0]  ssize,
   output logic [2:0]  dsize,
   output logic [2:0]  sinc,
   output logic [2:0]  dinc,
   output logic [2:0]  irqsrc,
   output logic        wfi,
   output logic [15:0] bsize,
   output logic [7:0]  bcount,
   output logic        start,
   input  logic        done,
   input  logic        busy,
   output logic        irq
);

   localparam logic [5:0] A_SADDR  = 6'h00;
   localparam logic [5:0] A_DADDR  = 6'h01;
   localparam logic [5:0] A_CFG    = 6'h02;
   localparam logic [5:0] A_BSIZE  = 6'h03;
   localparam logic [5:0] A_BCOUNT = 6'h04;
   localparam logic [5:0] A_CTRL   = 6'h05;
   localparam logic [5:0] A_STATUS = 6'h06;
   localparam logic [5:0] A_IE     = 6'h07;
   localparam logic [5:0] A_ICRA   = 6'h08;
   localparam logic [5:0] A_ICRV   = 6'h09;

   logic        dp_valid;
   logic [7:0]  dp_addr;
   logic [2:0]  dp_size;
   logic        dp_write;
   logic [15:0] cfg;
   logic        done_st;
   logic        serr_st;
   logic [3:0]  strb;
   logic [31:0] wmask;
   logic        wr_en;
   logic        cfg_wr;
   logic        ctrl_req;
   logic        start_ok;
   logic        start_err;
   logic        w1c_done;
   logic        w1c_serr;
   logic [5:0]  widx;
   logic        unused_ok;
`ifdef DMAC_REGS_IRQ_EN
   logic        ie;
`endif

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

   assign ssize  = cfg[2:0];
   assign dsize  = cfg[5:3];
   assign sinc   = cfg[8:6];
   assign dinc   = cfg[11:9];
   assign wfi    = cfg[12];
   assign irqsrc = cfg[15:13];

   assign unused_ok = ^{HADDR[31:8], HTRANS[0]};

   // Latch the accepted address phase for use in the data phase
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_addr  <= 8'h00;
         dp_size  <= 3'd0;
         dp_write <= 1'b0;
      end else if (HREADY) begin
         dp_valid <= HSEL & HTRANS[1];
         dp_addr  <= HADDR[7:0];
         dp_size  <= HSIZE;
         dp_write <= HWRITE;
      end else begin
         dp_valid <= 1'b0;
      end
   end

   // Byte-lane strobes from the latched size and low address bits
   always_comb begin
      strb = 4'b0000;
      unique case (dp_size)
         3'd0:    strb = 4'b0001 << dp_addr[1:0];
         3'd1:    strb = dp_addr[1] ? 4'b1100 : 4'b0011;
         3'd2:    strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
   end

   assign wmask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   assign widx  = dp_addr[7:2];
   assign wr_en = dp_valid & dp_write;
   assign cfg_wr = wr_en & ~busy;

   assign ctrl_req  = wr_en & (widx == A_CTRL) & strb[0] & HWDATA[0];
   assign start_ok  = ctrl_req & ~busy;
   assign start_err = ctrl_req & busy;
   assign w1c_done  = wr_en & (widx == A_STATUS) & strb[0] & HWDATA[1];
   assign w1c_serr  = wr_en & (widx == A_STATUS) & strb[0] & HWDATA[2];

   // Engine configuration registers, frozen while the engine is busy
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         saddr  <= 32'h0;
         daddr  <= 32'h0;
         icra   <= 32'h0;
         icrv   <= 32'h0;
         cfg    <= 16'h0;
         bsize  <= 16'h0;
         bcount <= 8'h0;
      end else if (cfg_wr) begin
         if (widx == A_SADDR)
            saddr <= (saddr & ~wmask) | (HWDATA & wmask);
         if (widx == A_DADDR)
            daddr <= (daddr & ~wmask) | (HWDATA & wmask);
         if (widx == A_ICRA)
            icra <= (icra & ~wmask) | (HWDATA & wmask);
         if (widx == A_ICRV)
            icrv <= (icrv & ~wmask) | (HWDATA & wmask);
         if (widx == A_CFG)
            cfg <= (cfg & ~wmask[15:0]) | (HWDATA[15:0] & wmask[15:0]);
         if (widx == A_BSIZE)
            bsize <= (bsize & ~wmask[15:0]) | (HWDATA[15:0] & wmask[15:0]);
         if (widx == A_BCOUNT)
            bcount <= (bcount & ~wmask[7:0]) | (HWDATA[7:0] & wmask[7:0]);
      end
   end

   // Start pulse and sticky status; a new done always beats a clear
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         start   <= 1'b0;
         done_st <= 1'b0;
         serr_st <= 1'b0;
      end else begin
         start <= start_ok;
         if (done)
            done_st <= 1'b1;
         else if (start_ok || w1c_done)
            done_st <= 1'b0;
         if (start_err)
            serr_st <= 1'b1;
         else if (w1c_serr)
            serr_st <= 1'b0;
      end
   end

`ifdef DMAC_REGS_IRQ_EN
   // Done interrupt enable
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         ie <= 1'b0;
      else if (wr_en && widx == A_IE && strb[0])
         ie <= HWDATA[0];
   end
   assign irq = done_st & ie;
`else
   assign irq = 1'b0;
`endif

   // Read mux driven from the data-phase state and current registers
   always_comb begin
      HRDATA = 32'h0;
      if (dp_valid && !dp_write) begin
         unique case (widx)
            A_SADDR:  HRDATA = saddr;
            A_DADDR:  HRDATA = daddr;
            A_CFG:    HRDATA = {16'h0, cfg};
            A_BSIZE:  HRDATA = {16'h0, bsize};
            A_BCOUNT: HRDATA = {24'h0, bcount};
            A_STATUS: HRDATA = {29'h0, serr_st, done_st, busy};
`ifdef DMAC_REGS_IRQ_EN
            A_IE:     HRDATA = {31'h0, ie};
`endif
            A_ICRA:   HRDATA = icra;
            A_ICRV:   HRDATA = icrv;
            default:  HRDATA = 32'h0;
         endcase
      end
   end

endmodule
